i2s_tx_multilane: RTL and testbench
===================================

# i2s_tx_multilane

Parametrised multi-lane I2S transmitter: buffers audio frames from the AXI-side sample path in an internal FIFO and serializes them onto NUM_LANES I2S data lines that share one generated bit clock and word clock. It is the successor to the single stereo I2S output path of the codec unit and sits between the sampler's voice mixer and the CODEC pins (ac_bclk, ac_pblrc, ac_pbdat). It adds configurable sample and slot widths, multiple lanes, frame buffering, graceful stop and underrun reporting.

## Interface
- SAMPLE_WIDTH, 24: bits per audio sample.
- SLOT_WIDTH, 32: bclk periods per channel slot; SLOT_WIDTH >= SAMPLE_WIDTH.
- NUM_LANES, 1: number of stereo data lines.
- FIFO_DEPTH, 8: frames buffered; power of 2, >= 2.
- BCLK_DIV, 4: axi_clk cycles per bclk half-period; >= 1.

- axi_clk  in  1  sole clock; all logic on rising edge.
- axi_aresetn  in  1  asynchronous active-low reset.
- enable  in  1  level; start/keep transmitting.
- mute  in  1  level; loaded frames replaced by zeros.
- s_data  in  2*NUM_LANES*SAMPLE_WIDTH  frame; lane i left = s_data[2*i*SAMPLE_WIDTH +: SAMPLE_WIDTH], right = s_data[(2*i+1)*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- s_valid  in  1  frame valid.
- s_ready  out  1  FIFO not full.
- underrun_clr  in  1  pulse; clears underrun.
- i2s_bclk  out  1  bit clock.
- i2s_wclk  out  1  word clock; 0 = left.
- i2s_data  out  NUM_LANES  serial data, one bit per lane.
- busy  out  1  high while not in IDLE.
- underrun  out  1  sticky: frame load found FIFO empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  frames stored.

## Operation
- FIFO: push on s_valid && s_ready. Not fall-through: a frame pushed in cycle t is poppable from t+1. s_ready = (fifo_level != FIFO_DEPTH).
- FSM states IDLE, RUN, STOP.
  - IDLE: bclk 0, wclk 1, data 0, dividers held at 0. enable=1 -> RUN next cycle; bit index initialised to 2*SLOT_WIDTH-1.
  - RUN: divider counts 0..BCLK_DIV-1; at terminal count bclk toggles. A bclk 1->0 toggle is a shift event. Bit index k advances 0..2*SLOT_WIDTH-1, wrapping.
  - enable=0 in RUN -> STOP; STOP finishes current frame; at shift event k=2*SLOT_WIDTH-1 enters IDLE without loading (FIFO untouched). enable=1 in STOP returns to RUN without interruption.
- Shift event k outputs per lane: k in [0, SLOT_WIDTH-1] left slot bit k, k in [SLOT_WIDTH, 2*SLOT_WIDTH-1] right slot bit k-SLOT_WIDTH; slot bit j = sample bit SAMPLE_WIDTH-1-j for j < SAMPLE_WIDTH, else 0 (MSB-first, left-justified).
- wclk (one-bclk lead): 0 for k = 2*SLOT_WIDTH-1 or k <= SLOT_WIDTH-2; 1 otherwise.
- Frame load at shift event k=2*SLOT_WIDTH-1 (including first event after entering RUN, which outputs data 0, wclk 0): if FIFO non-empty pop into shift register (zeros if mute); if empty load zeros (or see Configuration) and set underrun.
- underrun set has priority over underrun_clr in the same cycle.
- Reset at any time: all state cleared, FIFO emptied, outputs to reset values.

## Timing
- Reset values: i2s_bclk 0, i2s_wclk 1, i2s_data 0, s_ready 1, busy 0, underrun 0, fifo_level 0.
- All outputs registered. bclk period = 2*BCLK_DIV axi_clk cycles; frame = 2*SLOT_WIDTH bclk periods.
- First bclk rise BCLK_DIV cycles after entering RUN; first shift event 2*BCLK_DIV cycles after; left MSB on the following shift event.
- i2s_data and i2s_wclk change only in the cycle after bclk falls; stable across bclk rise.
- fifo_level updates the cycle after push/pop; simultaneous push and pop leaves it unchanged.

## Configuration
- I2S_TX_UNDERRUN_REPEAT_EN defined: on underrun the shift register reloads the last successfully popped frame (zeros if none since reset or if mute). Undefined: zeros loaded. underrun flag set in both cases.

## Test plan
- Defaults, push left=0xABCDEF right=0x123456, enable: wclk low then left slot shows 0xABCDEF MSB-first followed by 8 zeros, right slot 0x123456; bclk period 8 cycles.
- Push 9 frames with enable=0: s_ready falls after 8th, fifo_level=8, 9th not accepted.
- Enable with empty FIFO: underrun=1, data all zero; underrun_clr pulse coincident with another underrun keeps it 1; isolated clear -> 0.
- NUM_LANES=2, SAMPLE_WIDTH=16, SLOT_WIDTH=16, BCLK_DIV=1: lane0/lane1 carry distinct samples 0x8001/0x7FFE simultaneously, wclk toggles every 16 bclk.
- Drop enable mid-left slot: frame completes, busy falls at wrap, fifo_level unchanged; with REPEAT_EN, empty FIFO repeats prior frame 0x5A5A5A.
- Assert reset mid-frame: all outputs at reset values within same cycle, fifo_level=0.

Source files
------------

// File: rtl/i2s_tx_multilane.sv
// i2s_tx_multilane
// Multi-lane I2S transmitter. Audio frames from the sample path are buffered
// in a small FIFO and serialized MSB-first, left-justified, onto NUM_LANES
// data lines that share one bit clock and one word clock (word clock leads
// the data by one bit clock).
//
// Optional feature macro: I2S_TX_UNDERRUN_REPEAT_EN
//   defined   -> an underrun replays the last frame popped from the FIFO
//   undefined -> an underrun sends a frame of zeros
module i2s_tx_multilane #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int NUM_LANES    = 1,
  parameter int FIFO_DEPTH   = 8,
  parameter int BCLK_DIV     = 4
) (
  input  logic                                  axi_clk,
  input  logic                                  axi_aresetn,
  input  logic                                  enable,
  input  logic                                  mute,
  input  logic [2*NUM_LANES*SAMPLE_WIDTH-1:0]   s_data,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic                                  underrun_clr,
  output logic                                  i2s_bclk,
  output logic                                  i2s_wclk,
  output logic [NUM_LANES-1:0]                  i2s_data,
  output logic                                  busy,
  output logic                                  underrun,
  output logic [$clog2(FIFO_DEPTH):0]           fifo_level
);

  localparam int FRAME_W = 2 * NUM_LANES * SAMPLE_WIDTH;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int BITS    = 2 * SLOT_WIDTH;
  localparam int K_W     = $clog2(BITS);
  localparam int DIV_W   = $clog2(BCLK_DIV) + 1;

  localparam logic [K_W-1:0]   K_LAST      = K_W'(BITS - 1);
  localparam logic [K_W-1:0]   K_LEFT_LAST = K_W'(SLOT_WIDTH - 2);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(BCLK_DIV - 1);
  localparam logic [LVL_W-1:0] LVL_FULL    = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t                   state;
  logic [DIV_W-1:0]         div;
  logic [K_W-1:0]           k;
  logic [FRAME_W-1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [LVL_W-1:0]         level_next;
  logic [FRAME_W-1:0]       load_word;
  logic [NUM_LANES-1:0]     sr_msb;
  logic                     push;
  logic                     pop;
  logic                     shift_ev;
  logic                     wrap_ev;
  logic                     stop_now;
  logic                     load;
  logic                     wclk_next;

  // Place one lane's left/right samples into a two-slot word, each sample
  // left-justified in its slot so it shifts out MSB-first.
  function automatic logic [BITS-1:0] lane_slots(input logic [SAMPLE_WIDTH-1:0] l,
                                                 input logic [SAMPLE_WIDTH-1:0] r);
    logic [BITS-1:0] v;
    v = '0;
    v[BITS-1 -: SAMPLE_WIDTH]       = l;
    v[SLOT_WIDTH-1 -: SAMPLE_WIDTH] = r;
    return v;
  endfunction

  // A shift event is the bclk 1->0 toggle; the last bit of a frame is the
  // point where a new frame is loaded, unless a stop request ends the stream.
  assign shift_ev  = (state != IDLE) && (div == DIV_LAST) && i2s_bclk;
  assign wrap_ev   = shift_ev && (k == K_LAST);
  assign stop_now  = wrap_ev && (state == STOP) && !enable;
  assign load      = wrap_ev && !stop_now;
  assign pop       = load && (fifo_level != '0);
  assign push      = s_valid && s_ready;
  assign wclk_next = !((k == K_LAST) || (k <= K_LEFT_LAST));

  // Next FIFO occupancy; a push and pop in the same cycle cancel out.
  always_comb begin
    level_next = fifo_level;
    if (push && !pop)
      level_next = fifo_level + 1'b1;
    else if (!push && pop)
      level_next = fifo_level - 1'b1;
  end

  // Frame storage; contents need no reset because the level gates reads.
  always_ff @(posedge axi_clk) begin
    if (push)
      mem[wr_ptr] <= s_data;
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge axi_clk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      s_ready    <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= level_next;
      s_ready    <= (level_next != LVL_FULL);
    end
  end

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  logic [FRAME_W-1:0] last_frame;

  // Remember the most recent frame taken from the FIFO for underrun replay.
  always_ff @(posedge axi_clk or negedge axi_aresetn) begin
    if (!axi_aresetn)
      last_frame <= '0;
    else if (pop)
      last_frame <= mem[rd_ptr];
  end
`endif

  // Select the frame entering the shift registers at a load.
  always_comb begin
    load_word = '0;
    if (!mute) begin
      if (fifo_level != '0)
        load_word = mem[rd_ptr];
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
      else
        load_word = last_frame;
`endif
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [BITS-1:0] sr;
    logic [BITS-1:0] load_sr;

    assign load_sr   = lane_slots(load_word[2*g*SAMPLE_WIDTH +: SAMPLE_WIDTH],
                                  load_word[(2*g+1)*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
    assign sr_msb[g] = sr[BITS-1];

    // Per-lane shift register: cleared while idle so the first event after
    // start sends 0, reloaded at frame wrap, otherwise shifted each event.
    always_ff @(posedge axi_clk or negedge axi_aresetn) begin
      if (!axi_aresetn)
        sr <= '0;
      else if (state == IDLE)
        sr <= '0;
      else if (shift_ev && !stop_now)
        sr <= load ? load_sr : {sr[BITS-2:0], 1'b0};
    end
  end

  // Sticky underrun; a new underrun wins over a simultaneous clear.
  always_ff @(posedge axi_clk or negedge axi_aresetn) begin
    if (!axi_aresetn)
      underrun <= 1'b0;
    else if (load && (fifo_level == '0))
      underrun <= 1'b1;
    else if (underrun_clr)
      underrun <= 1'b0;
  end

  // Control FSM: clock divider, bclk/wclk generation, data output and
  // graceful stop at the end of the current frame.
  always_ff @(posedge axi_clk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state    <= IDLE;
      busy     <= 1'b0;
      div      <= '0;
      k        <= K_LAST;
      i2s_bclk <= 1'b0;
      i2s_wclk <= 1'b1;
      i2s_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          div      <= '0;
          k        <= K_LAST;
          i2s_bclk <= 1'b0;
          i2s_wclk <= 1'b1;
          i2s_data <= '0;
          if (enable) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        default: begin
          if (div == DIV_LAST) begin
            div      <= '0;
            i2s_bclk <= ~i2s_bclk;
          end else begin
            div <= div + 1'b1;
          end
          if (stop_now) begin
            state    <= IDLE;
            busy     <= 1'b0;
            k        <= K_LAST;
            i2s_wclk <= 1'b1;
            i2s_data <= '0;
          end else begin
            if (shift_ev) begin
              i2s_data <= sr_msb;
              i2s_wclk <= wclk_next;
              k        <= (k == K_LAST) ? '0 : k + 1'b1;
            end
            if (state == RUN && !enable)
              state <= STOP;
            else if (state == STOP && enable)
              state <= RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_tx_multilane.sv
// Testbench for i2s_tx_multilane: a default single-lane instance and a
// two-lane, 16-bit, fast-bclk instance. Expected serial bits are queued when
// frames are pushed and compared at every bclk rise.
module tb_i2s_tx_multilane;

  logic clk = 1'b0;
  logic rst_n;
  logic mute = 1'b0;

  logic        en0, vld0, rdy0, clr0, bclk0, wclk0, busy0, urun0;
  logic [47:0] sd0;
  logic [0:0]  data0;
  logic [3:0]  lvl0;

  logic        en1, vld1, rdy1, clr1, bclk1, wclk1, busy1, urun1;
  logic [63:0] sd1;
  logic [1:0]  data1;
  logic [3:0]  lvl1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] q0[$];
  logic [2:0] q1[$];
  logic [1:0] e0;
  logic [2:0] e1;
  logic       prev_b0 = 1'b0;
  logic       prev_b1 = 1'b0;
  bit         mon0_en = 1'b0;
  bit         mon1_en = 1'b0;

  always #5 clk = ~clk;

  i2s_tx_multilane dut0 (
    .axi_clk(clk), .axi_aresetn(rst_n), .enable(en0), .mute(mute),
    .s_data(sd0), .s_valid(vld0), .s_ready(rdy0), .underrun_clr(clr0),
    .i2s_bclk(bclk0), .i2s_wclk(wclk0), .i2s_data(data0), .busy(busy0),
    .underrun(urun0), .fifo_level(lvl0)
  );

  i2s_tx_multilane #(
    .SAMPLE_WIDTH(16), .SLOT_WIDTH(16), .NUM_LANES(2), .FIFO_DEPTH(8), .BCLK_DIV(1)
  ) dut1 (
    .axi_clk(clk), .axi_aresetn(rst_n), .enable(en1), .mute(mute),
    .s_data(sd1), .s_valid(vld1), .s_ready(rdy1), .underrun_clr(clr1),
    .i2s_bclk(bclk1), .i2s_wclk(wclk1), .i2s_data(data1), .busy(busy1),
    .underrun(urun1), .fifo_level(lvl1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare serial output against the queue at every bclk rise.
  always @(negedge clk) begin
    if (mon0_en && bclk0 && !prev_b0) begin
      check("dut0_expect_pending", q0.size() != 0, 1);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        check("dut0_wclk_data", {wclk0, data0}, e0);
      end
    end
    prev_b0 = bclk0;
    if (mon1_en && bclk1 && !prev_b1) begin
      check("dut1_expect_pending", q1.size() != 0, 1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        check("dut1_wclk_data", {wclk1, data1}, e1);
      end
    end
    prev_b1 = bclk1;
  end

  // Overall watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] fl(input int i);
    return 24'hC00000 ^ 24'(i * 24'h031337);
  endfunction

  // Samples seen at the first two bclk rises after leaving idle.
  task automatic push_start0();
    q0.push_back(2'b10);
    q0.push_back(2'b00);
  endtask

  task automatic push_frame0(input logic [23:0] l, input logic [23:0] r, input bit with_last);
    logic [23:0] s;
    logic        w;
    int          j;
    for (int k = 0; k < 64; k++) begin
      if (k < 63 || with_last) begin
        if (k < 32) begin s = l; j = k; end
        else begin s = r; j = k - 32; end
        s = (j < 24) ? (s << j) : 24'h0;
        w = !(k == 63 || k <= 30);
        q0.push_back({w, s[23]});
      end
    end
  endtask

  task automatic push_frame1(input logic [15:0] l0, input logic [15:0] r0,
                             input logic [15:0] l1, input logic [15:0] r1, input bit with_last);
    logic [15:0] a, b;
    logic        w;
    int          j;
    for (int k = 0; k < 32; k++) begin
      if (k < 31 || with_last) begin
        if (k < 16) begin a = l0; b = l1; j = k; end
        else begin a = r0; b = r1; j = k - 16; end
        a = a << j;
        b = b << j;
        w = !(k == 31 || k <= 14);
        q1.push_back({w, b[15], a[15]});
      end
    end
  endtask

  task automatic bclk_period(input int which, output int p);
    logic pb, cb;
    p  = -1;
    pb = which ? bclk1 : bclk0;
    cb = pb;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cb = which ? bclk1 : bclk0;
      if (cb && !pb) break;
      pb = cb;
    end
    pb = cb;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      cb = which ? bclk1 : bclk0;
      if (cb && !pb) begin p = i; break; end
      pb = cb;
    end
  endtask

  task automatic wait_q(input int which, input int n, input int limit);
    for (int i = 0; i < limit; i++) begin
      if ((which ? q1.size() : q0.size()) <= n) break;
      @(negedge clk);
    end
    check(which ? "dut1_queue_progress" : "dut0_queue_progress",
          (which ? q1.size() : q0.size()) <= n, 1);
  endtask

  task automatic wait_idle(input int which, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!(which ? busy1 : busy0)) break;
      @(negedge clk);
    end
    check(which ? "dut1_busy_fall" : "dut0_busy_fall", which ? busy1 : busy0, 0);
  endtask

  initial begin
    int  p;
    logic pw;
    rst_n = 1'b0;
    en0 = 0; vld0 = 0; clr0 = 0; sd0 = '0;
    en1 = 0; vld1 = 0; clr1 = 0; sd1 = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_bclk", bclk0, 0);
    check("rst_wclk", wclk0, 1);
    check("rst_data", data0, 0);
    check("rst_ready", rdy0, 1);
    check("rst_busy", busy0, 0);
    check("rst_underrun", urun0, 0);
    check("rst_level", lvl0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill the FIFO with enable low; the ninth frame must be refused
    for (int i = 0; i < 9; i++) begin
      sd0  = (i == 0) ? {24'h123456, 24'hABCDEF} : {~fl(i), fl(i)};
      vld0 = 1'b1;
      @(negedge clk);
      vld0 = 1'b0;
      check("fill_level", lvl0, (i < 8) ? i + 1 : 8);
      check("fill_ready", rdy0, (i < 7) ? 1 : 0);
    end

    // Stream frame 0 fully, stop partway through frame 1
    push_start0();
    push_frame0(24'hABCDEF, 24'h123456, 1'b1);
    push_frame0(fl(1), ~fl(1), 1'b0);
    mon0_en = 1'b1;
    en0 = 1'b1;
    bclk_period(0, p);
    check("dut0_bclk_period", p, 8);
    wait_q(0, 50, 2000);
    en0 = 1'b0;
    wait_idle(0, 1000);
    check("stop_level", lvl0, 6);
    check("stop_queue_empty", q0.size(), 0);
    check("stop_wclk", wclk0, 1);
    check("stop_bclk", bclk0, 0);
    check("stop_no_underrun", urun0, 0);

    // Reset in the middle of a frame
    mon0_en = 1'b0;
    en0 = 1'b1;
    repeat (300) @(negedge clk);
    check("pre_reset_busy", busy0, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bclk", bclk0, 0);
    check("mid_rst_wclk", wclk0, 1);
    check("mid_rst_data", data0, 0);
    check("mid_rst_ready", rdy0, 1);
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_underrun", urun0, 0);
    check("mid_rst_level", lvl0, 0);
    en0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Underrun with empty FIFO: zeros out, set beats clear, isolated clear works
    push_start0();
    push_frame0(24'h0, 24'h0, 1'b1);
    push_frame0(24'h0, 24'h0, 1'b0);
    mon0_en = 1'b1;
    en0 = 1'b1;
    pw = wclk0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pw && !wclk0) break;
      pw = wclk0;
    end
    check("underrun_first_load", urun0, 1);
    check("underrun_level", lvl0, 0);
    repeat (511) @(negedge clk);
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    check("underrun_set_over_clear", urun0, 1);
    repeat (2) @(negedge clk);
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    check("underrun_cleared", urun0, 0);
    en0 = 1'b0;
    wait_idle(0, 1000);
    check("underrun_queue_empty", q0.size(), 0);
    check("stop_does_not_load", urun0, 0);

    // One frame then an underrun: replay or zeros depending on the build
    sd0  = {24'hA5A5A5, 24'h5A5A5A};
    vld0 = 1'b1;
    @(negedge clk);
    vld0 = 1'b0;
    check("replay_push_level", lvl0, 1);
    push_start0();
    push_frame0(24'h5A5A5A, 24'hA5A5A5, 1'b1);
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    push_frame0(24'h5A5A5A, 24'hA5A5A5, 1'b0);
`else
    push_frame0(24'h0, 24'h0, 1'b0);
`endif
    en0 = 1'b1;
    wait_q(0, 50, 2000);
    en0 = 1'b0;
    wait_idle(0, 1000);
    check("replay_queue_empty", q0.size(), 0);
    check("replay_underrun", urun0, 1);
    check("replay_level", lvl0, 0);
    mon0_en = 1'b0;

    // Two lanes, 16-bit slots, bclk every two cycles
    sd1  = {16'hC3A5, 16'h7FFE, 16'h1234, 16'h8001};
    vld1 = 1'b1;
    @(negedge clk);
    vld1 = 1'b0;
    check("dut1_level", lvl1, 1);
    q1.push_back(3'b100);
    q1.push_back(3'b000);
    push_frame1(16'h8001, 16'h1234, 16'h7FFE, 16'hC3A5, 1'b0);
    mon1_en = 1'b1;
    en1 = 1'b1;
    bclk_period(1, p);
    check("dut1_bclk_period", p, 2);
    wait_q(1, 20, 500);
    en1 = 1'b0;
    wait_idle(1, 200);
    check("dut1_queue_empty", q1.size(), 0);
    check("dut1_level_after", lvl1, 0);
    check("dut1_no_underrun", urun1, 0);
    mon1_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
